mram_burst_ctrl: RTL and testbench

Parametrised MRAM burst controller for single and burst accesses, both read and write. It takes one serial command stream carrying address, length and write data, runs timed accesses on the asynchronous MRAM pins, and returns read data serially. It sits between the FPGA serial front-end and the MRAM device. It generalises the earlier fixed 20-bit/16-bit, write-address-only burst path: widths, access timing and burst length are parametrised, and it adds read bursts, wrapping bursts and input flow control.

---
 rtl/mram_burst_ctrl_pkg.sv | 25 ++
 rtl/mram_burst_ctrl_if.sv | 30 +++
 rtl/mram_burst_ctrl_access_timer.sv | 93 +++++++++
 rtl/mram_burst_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mram_burst_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mram_burst_ctrl_pkg.sv
// mram_burst_pkg: shared types and constants for the MRAM burst controller.
//   state_e              - controller FSM states
//   RW_WRITE / RW_READ   - encoding of the rw command bit
//   BURST_INCR / _WRAP   - encoding of the burst_type command bit
//   STROBE_OFF           - inactive level of the active-low MRAM strobes
package mram_burst_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWload,
        StWacc,
        StRacc,
        StRshift,
        StDone
    } state_e;

    localparam logic RW_WRITE   = 1'b0;
    localparam logic RW_READ    = 1'b1;
    localparam logic BURST_INCR = 1'b0;
    localparam logic BURST_WRAP = 1'b1;

    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/mram_burst_ctrl_if.sv
// mram_burst_ctrl_if: serial command/response channel of the MRAM burst controller.
//   start, rw, burst_type       - command strobe and its attributes
//   ser_in, ser_in_valid/ready  - serial header and write data, MSB first
//   ser_out, ser_out_valid      - serial read data, MSB first, no backpressure
//   busy, done                  - status; done is a one-cycle completion pulse
// Modports: master = front-end side, slave = controller side.
interface mram_burst_ctrl_if;

    logic start;
    logic rw;
    logic burst_type;
    logic ser_in;
    logic ser_in_valid;
    logic ser_in_ready;
    logic ser_out;
    logic ser_out_valid;
    logic busy;
    logic done;

    modport master (
        output start, rw, burst_type, ser_in, ser_in_valid,
        input  ser_in_ready, ser_out, ser_out_valid, busy, done
    );

    modport slave (
        input  start, rw, burst_type, ser_in, ser_in_valid,
        output ser_in_ready, ser_out, ser_out_valid, busy, done
    );

endinterface

// File: rtl/mram_burst_ctrl_access_timer.sv
// mram_access_timer: generates the registered, active-low MRAM strobe set for one
// access of ACC_CYC cycles.
//   clk, rst       - clock, synchronous active-high reset
//   start_acc      - pulse in the cycle before an access begins
//   is_write       - access type, sampled with start_acc
//   chip_en, write_en, out_en, lower_byte_en, upper_byte_en - strobes (active low)
//   acc_last       - high in the final cycle of the access
module mram_access_timer
    import mram_burst_pkg::*;
#(
    parameter int unsigned ACC_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_acc,
    input  logic is_write,
    output logic chip_en,
    output logic write_en,
    output logic out_en,
    output logic lower_byte_en,
    output logic upper_byte_en,
    output logic acc_last
);

    localparam int unsigned CW = $clog2(ACC_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          wr_q, wr_d;
    logic          ce_q, ce_d, we_q, we_d, oe_q, oe_d, be_q, be_d;

    assign acc_last = active_q && (cnt_q == CW'(ACC_CYC - 1));

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        wr_d     = wr_q;
        ce_d     = ce_q;
        we_d     = we_q;
        oe_d     = oe_q;
        be_d     = be_q;
        if (start_acc) begin
            active_d = 1'b1;
            cnt_d    = '0;
            wr_d     = is_write;
            ce_d     = !STROBE_OFF;
            be_d     = !STROBE_OFF;
            // write_en stays high in the first cycle so address/data settle first
            we_d     = STROBE_OFF;
            oe_d     = is_write ? STROBE_OFF : !STROBE_OFF;
        end else if (active_q) begin
            if (acc_last) begin
                active_d = 1'b0;
                ce_d     = STROBE_OFF;
                we_d     = STROBE_OFF;
                oe_d     = STROBE_OFF;
                be_d     = STROBE_OFF;
            end else begin
                cnt_d = cnt_q + CW'(1);
                // Next cycle index (0-based) is cnt_q+1; write_en low on 1..ACC_CYC-2
                we_d  = (wr_q && (int'(cnt_q) + 1 <= int'(ACC_CYC) - 2)) ? !STROBE_OFF
                                                                         : STROBE_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            wr_q     <= 1'b0;
            ce_q     <= STROBE_OFF;
            we_q     <= STROBE_OFF;
            oe_q     <= STROBE_OFF;
            be_q     <= STROBE_OFF;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            wr_q     <= wr_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            be_q     <= be_d;
        end
    end

    assign chip_en       = ce_q;
    assign write_en      = we_q;
    assign out_en        = oe_q;
    assign lower_byte_en = be_q;
    assign upper_byte_en = be_q;

endmodule

// File: rtl/mram_burst_ctrl.sv
// mram_burst_ctrl: serial-command MRAM burst controller (single/burst, read/write,
// incrementing or wrapping bursts).
//   clk, rst     - clock, synchronous active-high reset
//   bus          - serial command/response channel (slave side)
//   mram_dq      - MRAM data bus, driven only during a write access
//   mram_addr    - MRAM word address
//   chip_en, write_en, out_en, lower_byte_en, upper_byte_en - MRAM strobes, active low
module mram_burst_ctrl
    import mram_burst_pkg::*;
#(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned ACC_CYC  = 4,
    parameter int unsigned WRAP_LOG = 3
) (
    input  logic              clk,
    input  logic              rst,
    mram_burst_ctrl_if.slave  bus,
    inout  wire [DATA_W-1:0]  mram_dq,
    output logic [ADDR_W-1:0] mram_addr,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en
);

    localparam int unsigned HDR_W = ADDR_W + LEN_W;
    localparam int unsigned CNT_W = $clog2(HDR_W > DATA_W ? HDR_W : DATA_W);

    state_e             state_q, state_d;
    logic               rw_q, rw_d, bt_q, bt_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [LEN_W-1:0]   word_q, word_d, len_q, len_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, addr_step;
    logic [WRAP_LOG-1:0] wrap_low;
    logic [DATA_W-1:0]  sr_q, sr_d;
    logic [HDR_W-1:0]   hdr_shift;
    logic               start_acc, acc_last;

    // Wrapping bursts step only the low WRAP_LOG bits and keep the window base
    assign wrap_low  = addr_q[WRAP_LOG-1:0] + WRAP_LOG'(1);
    assign addr_step = (bt_q == BURST_WRAP) ? {addr_q[ADDR_W-1:WRAP_LOG], wrap_low}
                                            : addr_q + ADDR_W'(1);
    // Header shifts straight into {addr, len}: address first, len last
    assign hdr_shift = {addr_q[ADDR_W-2:0], len_q, bus.ser_in};

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        bt_d      = bt_q;
        bit_d     = bit_q;
        word_d    = word_q;
        len_d     = len_q;
        addr_d    = addr_q;
        sr_d      = sr_q;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rw_d    = bus.rw;
                    bt_d    = bus.burst_type;
                    bit_d   = '0;
                    word_d  = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (bus.ser_in_valid) begin
                    {addr_d, len_d} = hdr_shift;
                    bit_d           = bit_q + CNT_W'(1);
                    if (bit_q == CNT_W'(HDR_W - 1)) begin
                        bit_d = '0;
                        if (rw_q == RW_READ) begin
                            state_d   = StRacc;
                            start_acc = 1'b1;
                        end else begin
                            state_d = StWload;
                        end
                    end
                end
            end
            StWload: begin
                if (bus.ser_in_valid) begin
                    sr_d  = {sr_q[DATA_W-2:0], bus.ser_in};
                    bit_d = bit_q + CNT_W'(1);
                    if (bit_q == CNT_W'(DATA_W - 1)) begin
                        bit_d     = '0;
                        state_d   = StWacc;
                        start_acc = 1'b1;
                    end
                end
            end
            StWacc: begin
                if (acc_last) begin
                    if (word_q == len_q) begin
                        state_d = StDone;
                    end else begin
                        word_d  = word_q + LEN_W'(1);
                        addr_d  = addr_step;
                        state_d = StWload;
                    end
                end
            end
            StRacc: begin
                if (acc_last) begin
                    sr_d    = mram_dq;
                    bit_d   = '0;
                    state_d = StRshift;
                end
            end
            StRshift: begin
                sr_d  = {sr_q[DATA_W-2:0], 1'b0};
                bit_d = bit_q + CNT_W'(1);
                if (bit_q == CNT_W'(DATA_W - 1)) begin
                    bit_d = '0;
                    if (word_q == len_q) begin
                        state_d = StDone;
                    end else begin
                        word_d    = word_q + LEN_W'(1);
                        addr_d    = addr_step;
                        state_d   = StRacc;
                        start_acc = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rw_q    <= RW_WRITE;
            bt_q    <= BURST_INCR;
            bit_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            bt_q    <= bt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sr_q    <= sr_d;
        end
    end

    mram_access_timer #(
        .ACC_CYC (ACC_CYC)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .start_acc     (start_acc),
        .is_write      (rw_q == RW_WRITE),
        .chip_en       (chip_en),
        .write_en      (write_en),
        .out_en        (out_en),
        .lower_byte_en (lower_byte_en),
        .upper_byte_en (upper_byte_en),
        .acc_last      (acc_last)
    );

    assign mram_dq   = (state_q == StWacc) ? sr_q : {DATA_W{1'bz}};
    assign mram_addr = addr_q;

    assign bus.ser_in_ready  = (state_q == StHdr) || (state_q == StWload);
    assign bus.ser_out_valid = (state_q == StRshift);
    assign bus.ser_out       = (state_q == StRshift) && sr_q[DATA_W-1];
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StDone);

endmodule

// File: tb/tb_mram_burst_ctrl.sv
// tb_mram_burst_ctrl: scoreboard bench for mram_burst_ctrl with default parameters.
// Stimulus pushes expected accesses, read words and done tokens into queues; a
// negedge monitor pops and compares whenever the DUT shows an access, read data
// or a done pulse. Read data comes from a memory model: word = addr[15:0] ^ 0x5A5A.
module tb_mram_burst_ctrl;

    localparam int ACC_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] mram_dq;
    logic [19:0] mram_addr;
    logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
    logic        tb_drv, probe;
    logic [15:0] tb_val;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [35:0] exp_wr[$];
    logic [19:0] exp_ra[$];
    logic [15:0] exp_rd[$];
    int          exp_done[$];

    // Monitor state
    logic        prev_ce = 1'b1;
    int          acc_idx = 0;
    int          acc_cnt = 0;
    int          acc_start_cyc = 0;
    int          last_acc_cyc = 0;
    int          last_ser_cyc = 0;
    logic        acc_wr = 1'b0;
    logic [35:0] cur_wr = '0;
    logic [19:0] cur_ra = '0;
    logic [15:0] ser_sh = '0;
    int          nbits = 0;

    mram_burst_ctrl_if bus ();

    mram_burst_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .mram_dq       (mram_dq),
        .mram_addr     (mram_addr),
        .chip_en       (chip_en),
        .write_en      (write_en),
        .out_en        (out_en),
        .lower_byte_en (lower_byte_en),
        .upper_byte_en (upper_byte_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model drives dq during reads; probe drives a sentinel to test release
    always_comb begin
        tb_drv = 1'b0;
        tb_val = 16'h0000;
        if (!chip_en && !out_en) begin
            tb_drv = 1'b1;
            tb_val = mram_addr[15:0] ^ 16'h5A5A;
        end else if (probe) begin
            tb_drv = 1'b1;
            tb_val = 16'h1234;
        end
    end
    assign mram_dq = tb_drv ? tb_val : 16'hzzzz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_ce = 1'b1;
            acc_idx = 0;
            nbits   = 0;
        end else begin
            if (!chip_en) begin
                if (prev_ce) begin
                    acc_idx       = 0;
                    acc_start_cyc = cyc;
                    acc_cnt++;
                    acc_wr        = out_en;
                    if (acc_wr) begin
                        if (exp_wr.size() == 0) begin
                            flag("unexpected_write_access");
                            cur_wr = '0;
                        end else begin
                            cur_wr = exp_wr.pop_front();
                        end
                    end else begin
                        if (exp_ra.size() == 0) begin
                            flag("unexpected_read_access");
                            cur_ra = '0;
                        end else begin
                            cur_ra = exp_ra.pop_front();
                        end
                    end
                end
                if (acc_wr) begin
                    check("wr_addr", 64'(mram_addr), 64'(cur_wr[35:16]));
                    check("wr_dq", 64'(mram_dq), 64'(cur_wr[15:0]));
                    check("wr_we", 64'(write_en), (acc_idx == 1 || acc_idx == 2) ? 64'd0 : 64'd1);
                    check("wr_be", 64'({lower_byte_en, upper_byte_en}), 64'd0);
                end else begin
                    check("rd_addr", 64'(mram_addr), 64'(cur_ra));
                    check("rd_strobes", 64'({write_en, out_en, lower_byte_en, upper_byte_en}),
                          64'b1000);
                end
                acc_idx++;
                last_acc_cyc = cyc;
            end else if (!prev_ce) begin
                check("acc_len", 64'(acc_idx), 64'(ACC_CYC));
            end

            if (bus.ser_out_valid) begin
                ser_sh = {ser_sh[14:0], bus.ser_out};
                nbits++;
                if (nbits == 16) begin
                    nbits        = 0;
                    last_ser_cyc = cyc;
                    if (exp_rd.size() == 0) flag("unexpected_read_word");
                    else check("rd_word", 64'(ser_sh), 64'(exp_rd.pop_front()));
                end
            end

            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    int k;
                    k = exp_done.pop_front();
                    check("done_latency", 64'(cyc - (k == 1 ? last_ser_cyc : last_acc_cyc)), 64'd1);
                    check("busy_in_done", 64'(bus.busy), 64'd1);
                end
            end
            prev_ce = chip_en;
        end
    end

    task automatic send_bits(input logic [31:0] v, input int n, input int stall_at);
        for (int i = n - 1; i >= 0; i--) begin
            logic r;
            int   guard;
            if (i == stall_at) begin
                bus.ser_in_valid = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            bus.ser_in       = v[i];
            bus.ser_in_valid = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                r = bus.ser_in_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (!r && guard < 500);
            if (!r) begin
                flag("ser_in_ready_timeout");
                break;
            end
        end
        bus.ser_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.busy && guard < 3000);
        if (bus.busy) flag("busy_timeout");
    endtask

    task automatic pulse_start(input logic rwv, input logic btv);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.rw         = rwv;
        bus.burst_type = btv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // addrs/words hold up to four entries, first entry in the top bits
    task automatic run_cmd(input logic rwv, input logic btv, input logic [19:0] a,
                           input logic [7:0] len, input logic [79:0] addrs,
                           input logic [63:0] words, input int stall_at, input logic poke,
                           output int t_start);
        for (int i = 0; i <= int'(len); i++) begin
            logic [19:0] ea;
            logic [15:0] ew;
            ea = addrs[79 - 20*i -: 20];
            ew = words[63 - 16*i -: 16];
            if (rwv) begin
                exp_ra.push_back(ea);
                exp_rd.push_back(ew);
            end else begin
                exp_wr.push_back({ea, ew});
            end
        end
        exp_done.push_back(rwv ? 1 : 0);
        pulse_start(rwv, btv);
        t_start = cyc;
        send_bits({4'h0, a, len}, 28, stall_at);
        if (poke) begin
            bus.start = 1'b1;
            bus.rw    = ~rwv;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.rw    = rwv;
        end
        if (!rwv) begin
            for (int i = 0; i <= int'(len); i++) send_bits({16'h0, words[63 - 16*i -: 16]}, 16, -1);
        end
        if (poke) begin
            bus.start = 1'b1;
            bus.rw    = ~rwv;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_idle();
        check("done_count", 64'(exp_done.size()), 64'd0);
        check("queues_drained", 64'(exp_wr.size() + exp_ra.size() + exp_rd.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat1, lat2;
        rst              = 1'b1;
        probe            = 1'b0;
        bus.start        = 1'b0;
        bus.rw           = 1'b0;
        bus.burst_type   = 1'b0;
        bus.ser_in       = 1'b0;
        bus.ser_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        probe = 1'b1;
        @(negedge clk);
        check("rst_strobes", 64'({chip_en, write_en, out_en, lower_byte_en, upper_byte_en}),
              64'h1f);
        check("rst_addr", 64'(mram_addr), 64'd0);
        check("rst_outputs", 64'({bus.ser_out, bus.ser_out_valid, bus.ser_in_ready,
                                  bus.busy, bus.done}), 64'd0);
        check("rst_dq_released", 64'(mram_dq), 64'h1234);
        probe = 1'b0;

        // Single write
        run_cmd(1'b0, 1'b0, 20'h00010, 8'd0, {20'h00010, 60'h0}, {16'hA5C3, 48'h0}, -1,
                1'b0, t0);
        lat1 = acc_start_cyc - t0;
        check("write_word_latency", 64'(lat1), 64'd44);

        // Incrementing read across the top of the address space
        run_cmd(1'b1, 1'b0, 20'hFFFFE, 8'd3, {20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001},
                {16'hA5A4, 16'hA5A5, 16'h5A5A, 16'h5A5B}, -1, 1'b0, t0);

        // Wrapping write inside an 8-word window
        run_cmd(1'b0, 1'b1, 20'h00106, 8'd3, {20'h00106, 20'h00107, 20'h00100, 20'h00101},
                {16'h1111, 16'h2222, 16'h4444, 16'h8888}, -1, 1'b0, t0);

        // Same single write, unstalled and with a 5-cycle stall mid-header
        run_cmd(1'b0, 1'b0, 20'h00ABC, 8'd0, {20'h00ABC, 60'h0}, {16'h3C96, 48'h0}, -1,
                1'b0, t0);
        lat1 = acc_start_cyc - t0;
        run_cmd(1'b0, 1'b0, 20'h00ABC, 8'd0, {20'h00ABC, 60'h0}, {16'h3C96, 48'h0}, 15,
                1'b0, t0);
        lat2 = acc_start_cyc - t0;
        check("stall_delay", 64'(lat2 - lat1), 64'd5);

        // Reset during the second word of a 4-word write
        exp_wr.push_back({20'h00200, 16'h0F0F});
        exp_wr.push_back({20'h00201, 16'hF0F0});
        pulse_start(1'b0, 1'b0);
        send_bits({4'h0, 20'h00200, 8'd3}, 28, -1);
        send_bits({16'h0, 16'h0F0F}, 16, -1);
        send_bits({16'h0, 16'hF0F0}, 16, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        probe = 1'b1;
        @(negedge clk);
        check("abort_strobes", 64'({chip_en, write_en, out_en, lower_byte_en, upper_byte_en}),
              64'h1f);
        check("abort_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        check("abort_dq_released", 64'(mram_dq), 64'h1234);
        probe = 1'b0;
        exp_wr.delete();
        repeat (5) @(negedge clk);
        check("abort_idle", 64'({bus.busy, chip_en}), 64'b01);
        run_cmd(1'b0, 1'b0, 20'h00300, 8'd0, {20'h00300, 60'h0}, {16'h7E81, 48'h0}, -1,
                1'b0, t0);

        // start pulses while busy are ignored
        run_cmd(1'b0, 1'b0, 20'h00020, 8'd0, {20'h00020, 60'h0}, {16'h1357, 48'h0}, -1,
                1'b1, t0);
        repeat (10) @(negedge clk);
        check("idle_after_poke", 64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
